// File: rtl/dir_arbiter.sv
// Round-robin arbiter that serialises per-requester directory commands onto a single
// directory port, waits for the directory ack (or a timeout) and returns the sharer vector.
module dir_arbiter #(
   parameter int unsigned N_CPU              = 4,
   parameter int unsigned N_REQ              = N_CPU,
   parameter int unsigned TIMEOUT            = 16,
   parameter int unsigned DCACHE_INDEX_WIDTH = 8,
   parameter int unsigned DCACHE_TAG_WIDTH   = 12,
   // Width of the op_dir_t encoding; values are forwarded untouched.
   parameter int unsigned OP_WIDTH           = 2,
   parameter int unsigned CPU_ID_WIDTH       = (N_CPU > 1) ? $clog2(N_CPU) : 1
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [N_REQ-1:0]                         req_valid_i,
   input  logic [N_REQ-1:0][OP_WIDTH-1:0]           req_op_i,
   input  logic [N_REQ-1:0][DCACHE_INDEX_WIDTH-1:0] req_index_i,
   input  logic [N_REQ-1:0][DCACHE_TAG_WIDTH-1:0]   req_tag_i,
   output logic [N_REQ-1:0]                         req_ready_o,
   output logic [N_REQ-1:0]                         resp_valid_o,
   output logic [N_CPU-1:0]                         resp_sharers_o,
   output logic                                     resp_err_o,
   output logic                                     dir_req_o,
   output logic [OP_WIDTH-1:0]                      dir_op_o,
   output logic [DCACHE_INDEX_WIDTH-1:0]            dir_index_o,
   output logic [DCACHE_TAG_WIDTH-1:0]              dir_tag_o,
   output logic [CPU_ID_WIDTH-1:0]                  dir_cpu_id_o,
   input  logic [N_CPU-1:0]                         dir_sharers_i,
   input  logic                                     dir_ack_i,
   output logic                                     busy_o
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [PTR_W:0]   NReqW  = (PTR_W + 1)'(N_REQ);
   localparam logic [PTR_W-1:0] LastId = PTR_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;
   localparam logic [1:0] StResp  = 2'd3;

   logic [1:0]                    state_q, state_d;
   logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]              winner_q, winner_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [OP_WIDTH-1:0]           op_q, op_d;
   logic [DCACHE_INDEX_WIDTH-1:0] index_q, index_d;
   logic [DCACHE_TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [N_CPU-1:0]              sharers_q, sharers_d;
   logic                          err_q, err_d;

   logic                          any_req;
   logic [PTR_W-1:0]              winner;
   logic [PTR_W:0]                cand;

   // Scan from rr_ptr upwards (wrapping); descending loop leaves the closest candidate.
   always_comb begin
      any_req = |req_valid_i;
      winner  = rr_ptr_q;
      cand    = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(j);
         if (cand >= NReqW) begin
            cand = cand - NReqW;
         end
         if (req_valid_i[cand[PTR_W-1:0]]) begin
            winner = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      winner_d  = winner_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      index_d   = index_q;
      tag_d     = tag_q;
      sharers_d = sharers_q;
      err_d     = err_q;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               winner_d = winner;
               op_d     = req_op_i[winner];
               index_d  = req_index_i[winner];
               tag_d    = req_tag_i[winner];
               state_d  = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // An ack on the final count still wins over the timeout.
            if (dir_ack_i) begin
               sharers_d = dir_sharers_i;
               err_d     = 1'b0;
               state_d   = StResp;
            end else if (cnt_q == CntMax) begin
               sharers_d = '0;
               err_d     = 1'b1;
               state_d   = StResp;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StResp: begin
            rr_ptr_d = (winner_q == LastId) ? '0 : winner_q + PTR_W'(1);
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         rr_ptr_q  <= '0;
         winner_q  <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         index_q   <= '0;
         tag_q     <= '0;
         sharers_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         winner_q  <= winner_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         index_q   <= index_d;
         tag_q     <= tag_d;
         sharers_q <= sharers_d;
         err_q     <= err_d;
      end
   end

   // Outputs are forced low while reset is asserted, whatever state the flops hold.
   always_comb begin
      req_ready_o    = '0;
      resp_valid_o   = '0;
      resp_sharers_o = '0;
      resp_err_o     = 1'b0;
      dir_req_o      = 1'b0;
      dir_op_o       = '0;
      dir_index_o    = '0;
      dir_tag_o      = '0;
      dir_cpu_id_o   = '0;
      busy_o         = 1'b0;
      if (!reset) begin
         busy_o    = (state_q != StIdle);
         dir_req_o = (state_q == StIssue);
         if (state_q == StIdle) begin
            if (any_req) begin
               req_ready_o[winner] = 1'b1;
            end
         end else begin
            dir_op_o     = op_q;
            dir_index_o  = index_q;
            dir_tag_o    = tag_q;
            dir_cpu_id_o = CPU_ID_WIDTH'(winner_q);
         end
         if (state_q == StResp) begin
            resp_valid_o[winner_q] = 1'b1;
            resp_sharers_o         = sharers_q;
            resp_err_o             = err_q;
         end
      end
   end

endmodule

// File: tb/tb_dir_arbiter.sv
// Directed bench for dir_arbiter: latency-based transaction model checked every cycle,
// plus literal expectations inside each directed transaction.
module tb_dir_arbiter;

   localparam int N       = 4;
   localparam int TO      = 16;
   localparam int IDXW    = 8;
   localparam int TAGW    = 12;
   localparam int OPW     = 2;
   localparam int CIDW    = 2;
   localparam logic [1:0] READ_OP  = 2'd0;
   localparam logic [1:0] WRITE_OP = 2'd1;
   localparam logic [1:0] EVICT_OP = 2'd2;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [N-1:0]              req_valid_i;
   logic [N-1:0][OPW-1:0]     req_op_i;
   logic [N-1:0][IDXW-1:0]    req_index_i;
   logic [N-1:0][TAGW-1:0]    req_tag_i;
   logic [N-1:0]              req_ready_o;
   logic [N-1:0]              resp_valid_o;
   logic [N-1:0]              resp_sharers_o;
   logic                      resp_err_o;
   logic                      dir_req_o;
   logic [OPW-1:0]            dir_op_o;
   logic [IDXW-1:0]           dir_index_o;
   logic [TAGW-1:0]           dir_tag_o;
   logic [CIDW-1:0]           dir_cpu_id_o;
   logic [N-1:0]              dir_sharers_i;
   logic                      dir_ack_i;
   logic                      busy_o;

   int n_total = 0;
   int n_bad   = 0;

   dir_arbiter #(
      .N_CPU(N), .N_REQ(N), .TIMEOUT(TO), .DCACHE_INDEX_WIDTH(IDXW),
      .DCACHE_TAG_WIDTH(TAGW), .OP_WIDTH(OPW), .CPU_ID_WIDTH(CIDW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_index_i(req_index_i),
      .req_tag_i(req_tag_i), .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o),
      .resp_sharers_o(resp_sharers_o), .resp_err_o(resp_err_o), .dir_req_o(dir_req_o),
      .dir_op_o(dir_op_o), .dir_index_o(dir_index_o), .dir_tag_o(dir_tag_o),
      .dir_cpu_id_o(dir_cpu_id_o), .dir_sharers_i(dir_sharers_i), .dir_ack_i(dir_ack_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction model (cycle age since accept) ----------------
   bit           m_active = 1'b0;
   int           m_age, m_resp_age, m_rr = 0, m_win;
   logic [1:0]   m_op;
   logic [7:0]   m_idx;
   logic [11:0]  m_tag;
   logic [3:0]   m_sh;
   logic         m_err;

   always @(negedge clk) begin
      logic [3:0]  e_rdy, e_rv, e_sh;
      logic        e_err, e_dreq, e_busy;
      logic [1:0]  e_op, e_cid;
      logic [7:0]  e_idx;
      logic [11:0] e_tag;
      int          w;
      e_rdy = '0; e_rv = '0; e_sh = '0; e_err = 0; e_dreq = 0; e_busy = 0;
      e_op = '0; e_cid = '0; e_idx = '0; e_tag = '0; w = -1;
      if (!reset) begin
         if (!m_active) begin
            for (int k = N - 1; k >= 0; k--)
               if (req_valid_i[(m_rr + k) % N]) w = (m_rr + k) % N;
            if (w >= 0) e_rdy[w] = 1'b1;
         end else begin
            e_busy = 1; e_op = m_op; e_idx = m_idx; e_tag = m_tag; e_cid = 2'(m_win);
            e_dreq = (m_age == 1);
            if (m_age == m_resp_age) begin
               e_rv[m_win] = 1'b1; e_sh = m_sh; e_err = m_err;
            end
         end
      end
      check("cmp_ready", 32'(req_ready_o), 32'(e_rdy));
      check("cmp_resp_valid", 32'(resp_valid_o), 32'(e_rv));
      check("cmp_sharers", 32'(resp_sharers_o), 32'(e_sh));
      check("cmp_err", 32'(resp_err_o), 32'(e_err));
      check("cmp_dir_req", 32'(dir_req_o), 32'(e_dreq));
      check("cmp_dir_op", 32'(dir_op_o), 32'(e_op));
      check("cmp_dir_index", 32'(dir_index_o), 32'(e_idx));
      check("cmp_dir_tag", 32'(dir_tag_o), 32'(e_tag));
      check("cmp_dir_cpu_id", 32'(dir_cpu_id_o), 32'(e_cid));
      check("cmp_busy", 32'(busy_o), 32'(e_busy));
      // advance to the next cycle
      if (reset) begin
         m_active = 0; m_rr = 0;
      end else if (!m_active) begin
         if (w >= 0) begin
            m_active = 1; m_age = 1; m_resp_age = -1; m_win = w;
            m_op = req_op_i[w]; m_idx = req_index_i[w]; m_tag = req_tag_i[w];
         end
      end else if (m_age == m_resp_age) begin
         m_active = 0; m_rr = (m_win + 1) % N;
      end else begin
         if (m_age >= 2 && m_resp_age < 0) begin
            if (dir_ack_i) begin
               m_sh = dir_sharers_i; m_err = 0; m_resp_age = m_age + 1;
            end else if (m_age == TO + 1) begin
               m_sh = '0; m_err = 1; m_resp_age = m_age + 1;
            end
         end
         m_age++;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Entered 1 time unit after the edge of an idle cycle; returns likewise one cycle
   // after the response. ack_at = WAIT cycle index of the ack, -1 for none.
   task automatic txn(input logic [3:0] mask, input bit hold, input logic [3:0] exp_rdy,
                      input int id, input logic [1:0] op, input logic [7:0] idx,
                      input logic [11:0] tag, input int ack_at, input logic [3:0] sh);
      int   n_wait;
      logic exp_err;
      for (int p = 0; p < N; p++) begin
         req_op_i[p]    = (p == id) ? op  : ~op;
         req_index_i[p] = (p == id) ? idx : ~idx;
         req_tag_i[p]   = (p == id) ? tag : ~tag;
      end
      req_valid_i = mask;
      #1;
      check("accept_ready", 32'(req_ready_o), 32'(exp_rdy));
      check("accept_busy", 32'(busy_o), 32'd0);
      cyc();
      if (!hold) req_valid_i = '0;
      #1;
      check("issue_dir_req", 32'(dir_req_o), 32'd1);
      check("issue_cpu_id", 32'(dir_cpu_id_o), 32'(id));
      check("issue_op", 32'(dir_op_o), 32'(op));
      check("issue_index", 32'(dir_index_o), 32'(idx));
      check("issue_tag", 32'(dir_tag_o), 32'(tag));
      check("issue_ready", 32'(req_ready_o), 32'd0);
      exp_err = !(ack_at >= 0 && ack_at < TO);
      n_wait  = exp_err ? TO : ack_at + 1;
      for (int k = 0; k < n_wait; k++) begin
         cyc();
         if (k == ack_at) begin
            dir_ack_i = 1'b1; dir_sharers_i = sh;
         end
         #1;
         check("wait_dir_req", 32'(dir_req_o), 32'd0);
         check("wait_resp_valid", 32'(resp_valid_o), 32'd0);
         check("wait_tag_held", 32'(dir_tag_o), 32'(tag));
      end
      cyc();
      dir_ack_i = 1'b0; dir_sharers_i = '0;
      #1;
      check("resp_valid", 32'(resp_valid_o), 32'(exp_rdy));
      check("resp_sharers", 32'(resp_sharers_o), exp_err ? 32'd0 : 32'(sh));
      check("resp_err", 32'(resp_err_o), 32'(exp_err));
      cyc();
   endtask

   initial begin
      reset = 1'b1; req_valid_i = 4'b1010; req_op_i = '0; req_index_i = '0;
      req_tag_i = '0; dir_sharers_i = '0; dir_ack_i = 1'b0;
      cyc(); cyc();
      #1;
      check("reset_ready_gated", 32'(req_ready_o), 32'd0);
      check("reset_busy", 32'(busy_o), 32'd0);
      cyc();
      reset = 1'b0; req_valid_i = '0;
      cyc();

      // single request, nominal latency
      txn(4'b0100, 0, 4'b0100, 2, READ_OP, 8'h05, 12'h1A3, 0, 4'b0011);

      // fairness from rr_ptr = 0 with every port requesting
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      txn(4'b1111, 1, 4'b0001, 0, WRITE_OP, 8'h10, 12'h100, 0, 4'b0001);
      txn(4'b1111, 1, 4'b0010, 1, READ_OP,  8'h11, 12'h101, 0, 4'b0010);
      txn(4'b1111, 1, 4'b0100, 2, EVICT_OP, 8'h12, 12'h102, 0, 4'b0100);
      txn(4'b1111, 1, 4'b1000, 3, WRITE_OP, 8'h13, 12'h103, 0, 4'b1000);
      txn(4'b1111, 0, 4'b0001, 0, READ_OP,  8'h14, 12'h104, 0, 4'b1111);

      // timeout, then rr_ptr must be 2
      txn(4'b0010, 0, 4'b0010, 1, EVICT_OP, 8'h22, 12'h0F0, -1, 4'b1111);
      txn(4'b0111, 0, 4'b0100, 2, WRITE_OP, 8'h33, 12'h5A5, TO - 1, 4'b1001);
      txn(4'b1001, 0, 4'b1000, 3, READ_OP,  8'h44, 12'h777, 3, 4'b0110);

      // reset while waiting: port 3 accepted, reset at T+2, late ack at T+3
      for (int p = 0; p < N; p++) begin
         req_op_i[p] = EVICT_OP; req_index_i[p] = 8'h5C; req_tag_i[p] = 12'hABC;
      end
      req_valid_i = 4'b1000;
      #1;
      check("rw_accept", 32'(req_ready_o), 32'b1000);
      cyc();
      req_valid_i = '0;
      #1;
      check("rw_issue", 32'(dir_req_o), 32'd1);
      cyc();
      reset = 1'b1;
      #1;
      check("rw_busy_in_reset", 32'(busy_o), 32'd0);
      check("rw_index_in_reset", 32'(dir_index_o), 32'd0);
      cyc();
      reset = 1'b0; dir_ack_i = 1'b1; dir_sharers_i = 4'b1111;
      #1;
      check("rw_after_busy", 32'(busy_o), 32'd0);
      check("rw_after_resp", 32'(resp_valid_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         dir_ack_i = 1'b0; dir_sharers_i = '0;
         #1;
         check("rw_no_resp", 32'(resp_valid_o), 32'd0);
         check("rw_idle", 32'(busy_o), 32'd0);
      end
      cyc();
      txn(4'b1111, 0, 4'b0001, 0, WRITE_OP, 8'h66, 12'h321, 1, 4'b0101);

      // stray ack in IDLE
      dir_ack_i = 1'b1; dir_sharers_i = 4'b1010;
      #1;
      check("stray_busy", 32'(busy_o), 32'd0);
      for (int k = 0; k < 2; k++) begin
         cyc();
         dir_ack_i = 1'b0; dir_sharers_i = '0;
         #1;
         check("stray_resp", 32'(resp_valid_o), 32'd0);
         check("stray_sharers", 32'(resp_sharers_o), 32'd0);
         check("stray_dir_req", 32'(dir_req_o), 32'd0);
      end
      cyc();
      txn(4'b0110, 0, 4'b0010, 1, READ_OP, 8'h77, 12'h444, 0, 4'b0011);

      cyc();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
